xs3_conv_ctrl: RTL and testbench
================================

// Module: xs3_conv_ctrl
// PURPOSE
//  Sequential controller that turns an unsigned binary word into packed decimal digits.
//  It uses a multi-cycle shift-add-3 (double-dabble) sequence.
//  It then optionally applies the excess-3 (+3 per digit) recode.
//  This is the multi-digit, handshaked successor of the 4-bit combinational binary->BCD->XS3 path.
//  It sits between a binary producer and a display/decimal consumer, with valid/ready on both sides.
// PARAMETERS
//  WIDTH  8  binary input width in bits (>=4)
//  NDIG   3  decimal output digits; must satisfy 10**NDIG > 2**WIDTH-1 (elaboration-time check, $error otherwise)
// PORTS
//  clk        in   1         rising-edge clock
//  rst        in   1         synchronous, active-high reset
//  in_valid   in   1         bin_in is valid
//  in_ready   out  1         controller can accept bin_in (high only in IDLE)
//  bin_in     in   WIDTH     unsigned binary operand
//  out_valid  out  1         dig_out holds a finished result
//  out_ready  in   1         consumer accepts dig_out
//  dig_out    out  4*NDIG    packed digits, digit 0 in [3:0]; BCD or XS3 per CONFIGURATION
//  busy       out  1         high in SHIFT or XS3
// BEHAVIOUR
//  Reset (rst=1 at clk edge) values:
//   - state=IDLE, in_ready=1, out_valid=0, busy=0.
//   - dig_out=0, shift counter=0, internal bin/bcd regs=0.
//  rst overrides every other input. Reset mid-conversion aborts the conversion; no out_valid is produced for it.
//  FSM states: IDLE, SHIFT, XS3, DONE.
//   IDLE : in_ready=1. in_valid=1 at the edge captures the operand:
//          bin_reg<=bin_in, bcd_reg<=0, cnt<=0, goes to SHIFT.
//   SHIFT: one double-dabble step per edge:
//          - each 4-bit digit of bcd_reg that is >=5 gets +3 (4-bit add, no carry between digits);
//          - then {bcd_reg,bin_reg} shifts left 1.
//          - cnt increments. After the WIDTH-th step (cnt==WIDTH-1): go to XS3 if XS3_CODE_EN, else DONE.
//   XS3  : every digit gets +4'd3, written into dig_out. Go to DONE.
//   DONE : out_valid=1. dig_out is held stable until out_valid&&out_ready at an edge, then go to IDLE.
//  Outputs:
//   - Without the macro, dig_out<=bcd_reg on the SHIFT->DONE transition.
//   - Inputs are ignored while not in IDLE; in_valid held high simply waits.
//  Latency, from the capture edge E0 to the first cycle with out_valid=1:
//   - WIDTH+1 edges with XS3_CODE_EN; WIDTH edges without.
//  Throughput:
//   - One result per WIDTH+3 cycles (macro) or WIDTH+2 cycles (no macro), with out_ready held high.
//   - in_ready rises the cycle after the output handshake. No accept happens in DONE.
//  Boundaries:
//   - bin_in=0 yields all-zero BCD.
//   - bin_in=2**WIDTH-1 must be exact; no digit may exceed 9 before recode.
//   - out_ready high while out_valid=0 has no effect.
//   - in_valid and out_ready together in DONE: only the output handshake happens.
//  Combinational outputs: in_ready=(state==IDLE), busy=(state==SHIFT||state==XS3), out_valid=(state==DONE).
// CONFIGURATION
//  XS3_CODE_EN defined: the XS3 state is present and dig_out digits are excess-3 (0->4'h3, 9->4'hC).
//  XS3_CODE_EN undefined: the XS3 state is removed, dig_out is plain BCD, and latency is reduced by 1.
// TESTING
//  (defaults WIDTH=8, NDIG=3; results given as XS3 / BCD)
//  1. Reset release, then bin_in=0x00 with in_valid=1 and out_ready=1.
//     -> dig_out=12'h333 / 12'h000.
//     -> out_valid high exactly 9 edges (macro) / 8 edges (no macro) after capture.
//  2. Digit-boundary inputs:
//     -> bin_in=9: 12'h33C / 12'h009.
//     -> bin_in=10: 12'h343 / 12'h010.
//     -> bin_in=99: 12'h3CC / 12'h099.
//     -> bin_in=255: 12'h588 / 12'h255.
//  3. Backpressure: out_ready=0 for 5 cycles after out_valid.
//     -> dig_out and out_valid stay constant and in_ready stays 0.
//     -> out_ready=1 causes exactly one handshake, then IDLE.
//  4. Change bin_in and toggle in_valid while busy=1.
//     -> Result equals the originally captured operand.
//     -> The second operand is accepted only after returning to IDLE.
//  5. Assert rst for 1 cycle at cnt=4 during a conversion of 200.
//     -> Next cycle: IDLE, out_valid=0, dig_out=0.
//     -> No stale result; a new conversion of 37 gives 12'h36A / 12'h037.
//  6. Exhaustive sweep of 0..255 with random out_ready.
//     -> Every result matches the reference model (per-digit decimal, +3 if macro).
//     -> No transaction is dropped or duplicated.

Source files
------------

// File: rtl/xs3_conv_ctrl.sv
// Handshaked multi-cycle binary to packed-decimal converter (shift-add-3 sequence).
// Define XS3_CODE_EN to add the XS3 state and emit excess-3 digits instead of plain BCD.
module xs3_conv_ctrl #(
   parameter int WIDTH = 8,
   parameter int NDIG  = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [WIDTH-1:0]    bin_in,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [4*NDIG-1:0]   dig_out,
   output logic                busy
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int BCD_W = 4 * NDIG;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   function automatic longint unsigned pow10(input int n);
      longint unsigned p;
      p = 64'd1;
      for (int i = 0; i < n; i++) begin
         p = p * 64'd10;
      end
      return p;
   endfunction

   localparam longint unsigned MAX_BIN = (64'd1 << WIDTH) - 64'd1;

   // Too few digits would silently truncate the largest operands.
   if (pow10(NDIG) <= MAX_BIN) begin : g_ndig_check
      $error("xs3_conv_ctrl: NDIG=%0d cannot represent 2**%0d-1", NDIG, WIDTH);
   end

`ifdef XS3_CODE_EN
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      XS3   = 2'd2,
      DONE  = 2'd3
   } state_t;
`else
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd3
   } state_t;
`endif

   state_t               state;
   state_t               state_next;
   logic [WIDTH-1:0]     bin_reg;
   logic [BCD_W-1:0]     bcd_reg;
   logic [CNT_W-1:0]     cnt;

   logic [BCD_W-1:0]     bcd_adj;
   logic [BCD_W-1:0]     bcd_shift;
   logic [WIDTH-1:0]     bin_shift;
   logic                 last_step;

   // Digit correction is independent per nibble, so no carry ever crosses a digit.
   always_comb begin
      bcd_adj = '0;
      for (int i = 0; i < NDIG; i++) begin
         if (bcd_reg[4*i +: 4] >= 4'd5) begin
            bcd_adj[4*i +: 4] = bcd_reg[4*i +: 4] + 4'd3;
         end else begin
            bcd_adj[4*i +: 4] = bcd_reg[4*i +: 4];
         end
      end
   end

   always_comb begin
      bcd_shift = {bcd_adj[BCD_W-2:0], bin_reg[WIDTH-1]};
      bin_shift = {bin_reg[WIDTH-2:0], 1'b0};
      last_step = (state == SHIFT) && (cnt == LAST_CNT);
   end

`ifdef XS3_CODE_EN
   logic [BCD_W-1:0] bcd_xs3;

   always_comb begin
      bcd_xs3 = '0;
      for (int i = 0; i < NDIG; i++) begin
         bcd_xs3[4*i +: 4] = bcd_reg[4*i +: 4] + 4'd3;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (in_valid) begin
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            if (last_step) begin
`ifdef XS3_CODE_EN
               state_next = XS3;
`else
               state_next = DONE;
`endif
            end
         end
`ifdef XS3_CODE_EN
         XS3: begin
            state_next = DONE;
         end
`endif
         DONE: begin
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Datapath registers; dig_out only changes when a new result is produced.
   always_ff @(posedge clk) begin
      if (rst) begin
         bin_reg <= '0;
         bcd_reg <= '0;
         cnt     <= '0;
         dig_out <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  bin_reg <= bin_in;
                  bcd_reg <= '0;
                  cnt     <= '0;
               end
            end
            SHIFT: begin
               bin_reg <= bin_shift;
               bcd_reg <= bcd_shift;
               cnt     <= cnt + CNT_W'(1);
`ifndef XS3_CODE_EN
               if (last_step) begin
                  dig_out <= bcd_shift;
               end
`endif
            end
`ifdef XS3_CODE_EN
            XS3: begin
               dig_out <= bcd_xs3;
            end
`endif
            default: begin
            end
         endcase
      end
   end

`ifdef XS3_CODE_EN
   always_comb begin
      in_ready  = (state == IDLE);
      busy      = (state == SHIFT) || (state == XS3);
      out_valid = (state == DONE);
   end
`else
   always_comb begin
      in_ready  = (state == IDLE);
      busy      = (state == SHIFT);
      out_valid = (state == DONE);
   end
`endif

endmodule

// File: tb/tb_xs3_conv_ctrl.sv
// Directed bench for xs3_conv_ctrl; expectations follow XS3_CODE_EN when it is defined.
module tb_xs3_conv_ctrl;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  bin_in;
   logic        out_valid;
   logic        out_ready;
   logic [11:0] dig_out;
   logic        busy;

   int checks;
   int failures;

`ifdef XS3_CODE_EN
   localparam int LAT = 9;
`else
   localparam int LAT = 8;
`endif

   xs3_conv_ctrl #(.WIDTH(8), .NDIG(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .bin_in    (bin_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .dig_out   (dig_out),
      .busy      (busy)
   );

   // 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [11:0] pick(input logic [11:0] xs3, input logic [11:0] bcd);
`ifdef XS3_CODE_EN
      return xs3;
`else
      return bcd;
`endif
   endfunction

   // Reference built from decimal arithmetic, not from shift-add-3.
   function automatic logic [11:0] refModel(input int v);
      logic [3:0] d0, d1, d2;
      d0 = 4'(v % 10);
      d1 = 4'((v / 10) % 10);
      d2 = 4'((v / 100) % 10);
`ifdef XS3_CODE_EN
      d0 = d0 + 4'd3;
      d1 = d1 + 4'd3;
      d2 = d2 + 4'd3;
`endif
      return {d2, d1, d0};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic iv, input logic [7:0] bi, input logic ordy);
      in_valid  = iv;
      bin_in    = bi;
      out_ready = ordy;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic waitDone(output int edges);
      edges = 0;
      while (!out_valid && edges < 60) begin
         tick();
         edges++;
      end
   endtask

   // Captures val, measures edges to out_valid, checks digits, completes the handshake.
   task automatic runConv(input logic [7:0] val, input logic [11:0] exp, input string tag,
                          input logic hold_ready);
      int edges;
      checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      applyStimulus(1'b1, val, hold_ready);
      tick();
      in_valid = 1'b0;
      waitDone(edges);
      checkOutput({tag, "_latency"}, 32'(edges), 32'(LAT));
      checkOutput({tag, "_dig"}, 32'(dig_out), 32'(exp));
      out_ready = 1'b1;
      tick();
      checkOutput({tag, "_released"}, 32'(out_valid), 32'd0);
      out_ready = 1'b0;
   endtask

   initial begin
      int edges;
      int got;
      int iter;
      logic [11:0] seen;
      logic [11:0] held;

      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      applyStimulus(1'b0, 8'h00, 1'b0);
      tick();
      tick();
      checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_dig", 32'(dig_out), 32'd0);
      rst = 1'b0;
      tick();

      runConv(8'd0, pick(12'h333, 12'h000), "zero", 1'b1);
      tick();
      runConv(8'd9, pick(12'h33C, 12'h009), "nine", 1'b0);
      runConv(8'd10, pick(12'h343, 12'h010), "ten", 1'b0);
      runConv(8'd99, pick(12'h3CC, 12'h099), "n99", 1'b0);
      runConv(8'd255, pick(12'h588, 12'h255), "n255", 1'b0);

      // Backpressure on a result of 123.
      applyStimulus(1'b1, 8'd123, 1'b0);
      tick();
      in_valid = 1'b0;
      waitDone(edges);
      held = dig_out;
      checkOutput("bp_dig", 32'(held), 32'(pick(12'h456, 12'h123)));
      for (int i = 0; i < 5; i++) begin
         tick();
         checkOutput("bp_valid_hold", 32'(out_valid), 32'd1);
         checkOutput("bp_dig_hold", 32'(dig_out), 32'(held));
         checkOutput("bp_in_ready_low", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checkOutput("bp_released", 32'(out_valid), 32'd0);
      checkOutput("bp_idle", 32'(in_ready), 32'd1);
      tick();
      checkOutput("bp_no_second", 32'(out_valid), 32'd0);

      // Inputs wiggling while busy must not disturb the captured operand.
      applyStimulus(1'b1, 8'd42, 1'b0);
      tick();
      applyStimulus(1'b1, 8'd200, 1'b0);
      checkOutput("busy_high", 32'(busy), 32'd1);
      for (int i = 0; i < 4; i++) begin
         tick();
         in_valid = ~in_valid;
         bin_in   = bin_in + 8'd1;
         checkOutput("busy_in_ready_low", 32'(in_ready), 32'd0);
      end
      applyStimulus(1'b1, 8'd200, 1'b0);
      waitDone(edges);
      checkOutput("busy_dig", 32'(dig_out), 32'(pick(12'h375, 12'h042)));
      out_ready = 1'b1;
      tick();
      checkOutput("done_only_handshake", 32'(in_ready), 32'd1);
      checkOutput("done_not_busy", 32'(busy), 32'd0);
      out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      checkOutput("second_accepted", 32'(busy), 32'd1);
      waitDone(edges);
      checkOutput("second_dig", 32'(dig_out), 32'(pick(12'h533, 12'h200)));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;

      // Reset at cnt=4 while converting 200.
      applyStimulus(1'b1, 8'd200, 1'b0);
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("abort_in_ready", 32'(in_ready), 32'd1);
      checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
      checkOutput("abort_dig", 32'(dig_out), 32'd0);
      for (int i = 0; i < 12; i++) tick();
      checkOutput("abort_no_stale", 32'(out_valid), 32'd0);
      runConv(8'd37, pick(12'h36A, 12'h037), "after_abort", 1'b0);

      // Full sweep with random output backpressure.
      for (int v = 0; v < 256; v++) begin
         applyStimulus(1'b1, 8'(v), 1'b0);
         tick();
         in_valid = 1'b0;
         got  = 0;
         iter = 0;
         seen = '0;
         while (got == 0 && iter < 200) begin
            out_ready = 1'($urandom_range(0, 1));
            if (out_valid && out_ready) begin
               seen = dig_out;
               got  = 1;
            end
            tick();
            iter++;
         end
         out_ready = 1'b0;
         checkOutput("sweep_handshake", 32'(got), 32'd1);
         checkOutput("sweep_dig", 32'(seen), 32'(refModel(v)));
         checkOutput("sweep_no_dup", 32'(out_valid), 32'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
